// File: rtl/hood_pkg.sv
// rtl/hood_pkg.sv - shared range-hood encodings and hurricane controller state type
package hood_pkg;

  // Mode encodings shared with the mode state machine
  localparam logic [2:0] MODE_STANDBY   = 3'b000;
  localparam logic [2:0] MODE_1         = 3'b001;
  localparam logic [2:0] MODE_2         = 3'b010;
  localparam logic [2:0] MODE_HURRICANE = 3'b011;
  localparam logic [2:0] MODE_CLEAN     = 3'b100;

  // Default system clock rate in cycles per second
  localparam int DEFAULT_CLK_HZ = 100_000_000;

  // Hurricane controller states
  typedef enum logic [2:0] {
    HC_OFF       = 3'd0,
    HC_READY     = 3'd1,
    HC_RUN       = 3'd2,
    HC_WIND_DOWN = 3'd3,
    HC_EXIT      = 3'd4,
    HC_USED      = 3'd5
  } hc_state_t;

endpackage

// File: rtl/sec_tick.sv
// rtl/sec_tick.sv - one-cycle pulse per second, restartable so the first second is full length
module sec_tick
  import hood_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  // A restart in the same cycle suppresses the pulse so a reload never also counts down
  assign tick = en && !clr && (cnt == LAST);

  // Divider counts 0..CLK_HZ-1 while enabled; clr restarts the second from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hurricane_ctrl.sv
// rtl/hurricane_ctrl.sv - hurricane (mode 3) run/wind-down timer and once-per-power-on grant
module hurricane_ctrl
  import hood_pkg::*;
#(
  parameter int CLK_HZ  = DEFAULT_CLK_HZ,
  parameter int RUN_SEC = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_state,
  input  logic [2:0] mode_state,
  input  logic       menu_btn,
  output logic       hurricane_mode_enabled,
  output logic       return_state,
  output logic       hurricane_active,
  output logic [6:0] remaining_sec
);

  localparam logic [6:0] RUN_LOAD = 7'(RUN_SEC);

  hc_state_t state;
  logic      in_hurricane;
  logic      counting;
  logic      tick_clr;
  logic      tick_en;
  logic      tick;

  assign in_hurricane = (mode_state == MODE_HURRICANE);
  assign counting     = (state == HC_RUN) || (state == HC_WIND_DOWN);
  // Restart the second on entry and on the menu-requested reload
  assign tick_clr     = in_hurricane && ((state == HC_READY) || ((state == HC_RUN) && menu_btn));
  assign tick_en      = counting && in_hurricane && machine_state;

  sec_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .en  (tick_en),
    .tick(tick)
  );

  // Mode-3 grant FSM with registered outputs and the seconds countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= HC_OFF;
      hurricane_mode_enabled <= 1'b0;
      return_state           <= 1'b0;
      hurricane_active       <= 1'b0;
      remaining_sec          <= '0;
    end else if (!machine_state) begin
      // Power-off also forgets that hurricane mode was already used
      state                  <= HC_OFF;
      hurricane_mode_enabled <= 1'b0;
      return_state           <= 1'b0;
      hurricane_active       <= 1'b0;
      remaining_sec          <= '0;
    end else begin
      case (state)
        HC_OFF: begin
          state                  <= HC_READY;
          hurricane_mode_enabled <= 1'b1;
        end
        HC_READY: begin
          hurricane_mode_enabled <= 1'b1;
          if (in_hurricane) begin
            state            <= HC_RUN;
            remaining_sec    <= RUN_LOAD;
            hurricane_active <= 1'b1;
          end
        end
        HC_RUN, HC_WIND_DOWN: begin
          if (!in_hurricane) begin
            // Mode FSM left mode 3 on its own: grant is spent
            state                  <= HC_USED;
            hurricane_mode_enabled <= 1'b0;
            hurricane_active       <= 1'b0;
            remaining_sec          <= '0;
          end else if ((state == HC_RUN) && menu_btn) begin
            state         <= HC_WIND_DOWN;
            remaining_sec <= RUN_LOAD;
          end else if (tick) begin
            if (remaining_sec <= 7'd1) begin
              state                  <= HC_EXIT;
              remaining_sec          <= '0;
              hurricane_mode_enabled <= 1'b0;
              hurricane_active       <= 1'b0;
              return_state           <= (state == HC_RUN);
            end else begin
              remaining_sec <= remaining_sec - 7'd1;
            end
          end
        end
        HC_EXIT: begin
          // Hold return_state until the mode FSM has acted on it
          if (!in_hurricane) begin
            state        <= HC_USED;
            return_state <= 1'b0;
          end
        end
        default: begin
          state                  <= HC_USED;
          hurricane_mode_enabled <= 1'b0;
          return_state           <= 1'b0;
          hurricane_active       <= 1'b0;
          remaining_sec          <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hurricane_ctrl.sv
// tb/tb_hurricane_ctrl.sv - self-checking bench for hurricane_ctrl
module tb_hurricane_ctrl;

  localparam int HZ  = 4;
  localparam int SEC = 3;
  localparam int SEC_CYC = HZ * SEC;

  localparam int P_OFF = 0, P_READY = 1, P_RUN = 2, P_WIND = 3, P_EXIT = 4, P_USED = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ms = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       menu = 1'b0;
  logic       en, ret, act;
  logic [6:0] rem;

  int n_total = 0;
  int n_pass  = 0;

  hurricane_ctrl #(
    .CLK_HZ (HZ),
    .RUN_SEC(SEC)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .machine_state         (ms),
    .mode_state            (mode),
    .menu_btn              (menu),
    .hurricane_mode_enabled(en),
    .return_state          (ret),
    .hurricane_active      (act),
    .remaining_sec         (rem)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input int e_en, input int e_ret, input int e_act, input int e_rem);
    check({name, ".enable"}, int'(en), e_en);
    check({name, ".return"}, int'(ret), e_ret);
    check({name, ".active"}, int'(act), e_act);
    check({name, ".remaining"}, int'(rem), e_rem);
  endtask

  // Counts edges until enable falls, bounded; a timeout shows up as an out-of-range count
  task automatic wait_drop(output int n);
    n = 0;
    while (en && n < 40) begin
      tick1();
      n++;
    end
  endtask

  task automatic power_cycle();
    ms = 1'b0; mode = 3'd0; menu = 1'b0;
    tick1();
    ms = 1'b1;
    tick1();
  endtask

  // Reference model: phase plus the cycle the current countdown started; seconds left
  // are derived from elapsed cycles rather than from a tick counter
  int m_ph = P_OFF, m_t0 = 0, m_cyc = 0;
  bit m_ret = 1'b0;
  bit model_on = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= P_OFF; m_ret <= 1'b0; m_cyc <= 0; m_t0 <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (!ms) begin
        m_ph <= P_OFF; m_ret <= 1'b0;
      end else begin
        case (m_ph)
          P_OFF:   m_ph <= P_READY;
          P_READY: if (mode == 3'd3) begin m_ph <= P_RUN; m_t0 <= m_cyc + 1; end
          P_RUN, P_WIND: begin
            if (mode != 3'd3) m_ph <= P_USED;
            else if (m_ph == P_RUN && menu) begin m_ph <= P_WIND; m_t0 <= m_cyc + 1; end
            else if (m_cyc + 1 - m_t0 == SEC_CYC) begin m_ph <= P_EXIT; m_ret <= (m_ph == P_RUN); end
          end
          P_EXIT:  if (mode != 3'd3) begin m_ph <= P_USED; m_ret <= 1'b0; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      automatic bit counting = (m_ph == P_RUN) || (m_ph == P_WIND);
      check("model.enable", int'(en), int'(m_ph == P_READY || counting));
      check("model.active", int'(act), int'(counting));
      check("model.return", int'(ret), int'(m_ph == P_EXIT && m_ret));
      check("model.remaining", int'(rem), counting ? SEC - (m_cyc - m_t0) / HZ : 0);
    end
  end

  typedef struct {
    logic       ms;
    logic [2:0] mode;
    logic       menu;
    int         e_en, e_ret, e_act, e_rem;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic v_ms, logic [2:0] v_mode, logic v_menu, int v_en, int v_ret, int v_act, int v_rem);
    vec_t v;
    v.ms = v_ms; v.mode = v_mode; v.menu = v_menu;
    v.e_en = v_en; v.e_ret = v_ret; v.e_act = v_act; v.e_rem = v_rem;
    vecs.push_back(v);
  endfunction

  initial begin
    int n;

    // Full run from READY: entry, 3/2/1 at 4-cycle spacing, expiry to mode 2, then USED
    add(1, 3'd3, 0, 1, 0, 1, 3);
    for (int i = 0; i < 3; i++) add(1, 3'd3, 0, 1, 0, 1, 3);
    for (int i = 0; i < 4; i++) add(1, 3'd3, 0, 1, 0, 1, 2);
    for (int i = 0; i < 4; i++) add(1, 3'd3, 0, 1, 0, 1, 1);
    add(1, 3'd3, 0, 0, 1, 0, 0);
    add(1, 3'd3, 0, 0, 1, 0, 0);
    add(1, 3'd2, 0, 0, 0, 0, 0);
    add(1, 3'd3, 0, 0, 0, 0, 0);

    // Reset state
    rst = 1'b1;
    tick1();
    tick1();
    model_on = 1'b1;
    check_all("reset", 0, 0, 0, 0);

    // Reset mid-RUN clears outputs without waiting for an edge
    rst = 1'b0; ms = 1'b1;
    tick1();
    check("power_on.enable", int'(en), 1);
    mode = 3'd3;
    tick1();
    check("entry.remaining", int'(rem), SEC);
    tick1();
    tick1();
    rst = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0, 0);
    tick1();
    mode = 3'd0;
    rst = 1'b0;
    tick1();
    check("ready_after_reset.enable", int'(en), 1);

    // Table-driven full run
    foreach (vecs[i]) begin
      ms = vecs[i].ms; mode = vecs[i].mode; menu = vecs[i].menu;
      tick1();
      check_all($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_ret, vecs[i].e_act, vecs[i].e_rem);
    end

    // Power cycle re-arms the one-shot; a new entry runs a full countdown
    power_cycle();
    check("rearm.enable", int'(en), 1);
    mode = 3'd3;
    tick1();
    check("rearm_entry.remaining", int'(rem), SEC);
    wait_drop(n);
    check("rearm.entry_to_drop_in_range", int'(n + 1 >= SEC_CYC - 1 && n + 1 <= SEC_CYC + 1), 1);
    check("rearm.return", int'(ret), 1);

    // Menu press 5 cycles into RUN starts a full wind-down ending in standby
    power_cycle();
    mode = 3'd3;
    tick1();
    for (int i = 0; i < 4; i++) tick1();
    check("pre_menu.remaining", int'(rem), 2);
    menu = 1'b1;
    tick1();
    menu = 1'b0;
    check_all("menu_reload", 1, 0, 1, SEC);
    wait_drop(n);
    check("wind.press_to_drop_in_range", int'(n + 1 >= SEC_CYC - 1 && n + 1 <= SEC_CYC + 1), 1);
    check("wind.return", int'(ret), 0);
    mode = 3'd0;
    tick1();

    // Menu coincident with a tick reloads without decrementing; second press ignored
    power_cycle();
    mode = 3'd3;
    tick1();
    for (int i = 0; i < 3; i++) tick1();
    menu = 1'b1;
    tick1();
    menu = 1'b0;
    check("coincident.remaining", int'(rem), SEC);
    tick1();
    tick1();
    menu = 1'b1;
    tick1();
    menu = 1'b0;
    check("wind_menu_ignored.remaining", int'(rem), SEC);
    tick1();
    check("wind_first_tick.remaining", int'(rem), SEC - 1);
    wait_drop(n);
    check("coincident.tick_to_drop_in_range", int'(n >= SEC_CYC - HZ - 1 && n <= SEC_CYC - HZ + 1), 1);
    check("coincident.return", int'(ret), 0);

    // External exit from mode 3 mid-RUN goes straight to USED
    power_cycle();
    mode = 3'd3;
    tick1();
    tick1();
    tick1();
    mode = 3'd0;
    tick1();
    check_all("external_exit", 0, 0, 0, 0);
    mode = 3'd3;
    tick1();
    check("used_no_regrant.enable", int'(en), 0);

    // Randomized traffic checked against the reference model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) ms = ~ms;
      else if (!ms && $urandom_range(0, 3) == 0) ms = 1'b1;
      if ($urandom_range(0, 11) == 0) mode = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 4)) : 3'd3;
      menu = ($urandom_range(0, 9) == 0);
      tick1();
    end

    model_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
